ripple_count_monitor: RTL and testbench
=======================================

RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (legal 2..3).
REQ-002 SHALL have parameter STABLE_CYCLES, default 2, consecutive equal samples required before commit (legal 1..7).
REQ-003 SHALL have parameter WRAP_W, default 8, wrap counter width.
REQ-004 SHALL have port clk  input  1  single clock for all state.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port cnt_in  input  4  count from the upstream 4-bit asynchronous ripple counter, not synchronous to clk.
REQ-007 SHALL have port thresh  input  4  match value, quasi-static.
REQ-008 SHALL have port clr  input  1  synchronous clear of wrap_cnt, ovf and pending event.
REQ-009 SHALL have port cnt_sync  output  4  last committed (settled) count.
REQ-010 SHALL have port stable  output  1  high while stab_cnt == STABLE_CYCLES.
REQ-011 SHALL have port match_p  output  1  one-cycle pulse: commit with new value == thresh.
REQ-012 SHALL have port wrap_p  output  1  one-cycle pulse: commit with new value < previous cnt_sync.
REQ-013 SHALL have port wrap_cnt  output  WRAP_W  saturating count of wraps.
REQ-014 SHALL have port evt_valid  output  1  event available.
REQ-015 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-016 SHALL have port evt_data  output  5  {wrap flag, committed value}.
REQ-017 SHALL have port ovf  output  1  sticky: event dropped.

Function
REQ-018 SHALL pass cnt_in through SYNC_STAGES flops (all 4 bits), last stage s, plus one delay flop s_d.
REQ-019 SHALL hold stab_cnt: 0 when s != s_d, else increment, saturating at STABLE_CYCLES.
REQ-020 SHALL commit (cnt_sync <= s_d) on an edge where stab_cnt == STABLE_CYCLES and s_d != cnt_sync; no commit otherwise.
REQ-021 SHALL, with defaults, update cnt_sync on the 6th rising edge after a single clean cnt_in change.
REQ-022 SHALL ignore ripple glitches shorter than the stability window: transient values never commit.
REQ-023 SHALL, on commit with new < old, pulse wrap_p and increment wrap_cnt, saturating at 2^WRAP_W-1.
REQ-024 SHALL, on commit with new == thresh, pulse match_p; match_p and wrap_p may assert together.
REQ-025 SHALL treat handshake as valid/ready: transfer on edge with evt_valid && evt_ready; evt_data stable while evt_valid && !evt_ready.
REQ-026 SHALL, on commit when evt_valid == 0 or transfer occurs that edge, load evt_data and set evt_valid = 1.
REQ-027 SHALL, on commit while evt_valid && !evt_ready, drop the new event, keep old evt_data, set ovf = 1.
REQ-028 SHALL clear evt_valid on transfer edge with no simultaneous commit.
REQ-029 SHALL on clr: wrap_cnt = 0, ovf = 0, evt_valid = 0; clr beats same-cycle commit for these outputs, but cnt_sync still commits and pulses still fire.
REQ-030 SHALL keep ovf set until clr or reset.

Reset
REQ-031 SHALL on rst low immediately force: sync flops, s_d, cnt_sync = 0; stab_cnt = 0; stable, match_p, wrap_p, evt_valid, ovf = 0; wrap_cnt = 0; evt_data = 0.
REQ-032 SHALL resume operation on the first clk edge after rst deasserts; reset mid-settling discards the pending value.

Verification
REQ-033 SHALL test: rst low, cnt_in = 0x0 -> 0x3, evt_ready = 1 -> cnt_sync = 3 on 6th edge, evt_data = 0x03 one cycle.
REQ-034 SHALL test: cnt_in 0x3 -> 0x2 for 1 cycle -> 0x3 -> no commit, no event, stable drops then recovers.
REQ-035 SHALL test: cnt_sync = 0xF, cnt_in -> 0x0 -> wrap_p = 1, wrap_cnt = 1, evt_data = 0x10.
REQ-036 SHALL test: evt_ready = 0, two commits (1 then 2) -> evt_data stays 0x01, ovf = 1; clr -> ovf = 0, evt_valid = 0.
REQ-037 SHALL test: thresh = 0x5, cnt_in -> 0x5 -> match_p one cycle; 255 wraps then one more -> wrap_cnt holds 255.
REQ-038 SHALL test: rst asserted mid-settling -> all outputs 0 asynchronously; value not committed after release until re-settled.

Source files
------------

// File: rtl/ripple_count_monitor.sv
// Captures a free-running asynchronous 4-bit ripple counter. Only settled values are committed, and
// each commit raises wrap/match pulses and emits an event on a valid/ready port.
module ripple_count_monitor #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned WRAP_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cnt_in,
  input  logic [3:0]        thresh,
  input  logic              clr,
  output logic [3:0]        cnt_sync,
  output logic              stable,
  output logic              match_p,
  output logic              wrap_p,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [4:0]        evt_data,
  output logic              ovf
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAB_W = 3;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][CNT_W-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]  s_d_q, s_d_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [CNT_W-1:0]  cnt_sync_q, cnt_sync_d;
  logic              stable_q, stable_d;
  logic              match_q, match_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              evt_valid_q, evt_valid_d;
  logic [4:0]        evt_data_q, evt_data_d;
  logic              ovf_q, ovf_d;

  logic [CNT_W-1:0]  s_c;
  logic              commit_c;
  logic              xfer_c;
  logic              is_wrap_c;

  // Next-state logic: settle filter, commit decision, counters and event slot
  always_comb begin
    sync_d      = sync_q;
    s_d_d       = s_d_q;
    stab_d      = stab_q;
    cnt_sync_d  = cnt_sync_q;
    stable_d    = stable_q;
    match_d     = 1'b0;
    wrap_d      = 1'b0;
    wrap_cnt_d  = wrap_cnt_q;
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    ovf_d       = ovf_q;

    if (SYNC_STAGES > 1) begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sync_d[i] = sync_q[i-1];
      end
    end
    sync_d[0] = cnt_in;
    s_c       = sync_q[SYNC_STAGES-1];
    s_d_d     = s_c;

    if (s_c != s_d_q) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
    end
    stable_d = (stab_d == STAB_MAX);

    commit_c  = (stab_q == STAB_MAX) && (s_d_q != cnt_sync_q);
    is_wrap_c = (s_d_q < cnt_sync_q);
    xfer_c    = evt_valid_q && evt_ready;

    if (commit_c) begin
      cnt_sync_d = s_d_q;
      wrap_d     = is_wrap_c;
      match_d    = (s_d_q == thresh);
      if (is_wrap_c && (wrap_cnt_q != {WRAP_W{1'b1}})) begin
        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
      if (!evt_valid_q || xfer_c) begin
        evt_valid_d = 1'b1;
        evt_data_d  = {is_wrap_c, s_d_q};
      end else begin
        ovf_d = 1'b1;
      end
    end else if (xfer_c) begin
      evt_valid_d = 1'b0;
    end

    // Clear wins over a same-cycle commit for the bookkeeping outputs only
    if (clr) begin
      wrap_cnt_d  = '0;
      ovf_d       = 1'b0;
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      s_d_q       <= '0;
      stab_q      <= '0;
      cnt_sync_q  <= '0;
      stable_q    <= 1'b0;
      match_q     <= 1'b0;
      wrap_q      <= 1'b0;
      wrap_cnt_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      s_d_q       <= s_d_d;
      stab_q      <= stab_d;
      cnt_sync_q  <= cnt_sync_d;
      stable_q    <= stable_d;
      match_q     <= match_d;
      wrap_q      <= wrap_d;
      wrap_cnt_q  <= wrap_cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cnt_sync  = cnt_sync_q;
  assign stable    = stable_q;
  assign match_p   = match_q;
  assign wrap_p    = wrap_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor using default parameters.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_ripple_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_in;
  logic [3:0] thresh;
  logic       clr;
  logic [3:0] cnt_sync;
  logic       stable;
  logic       match_p;
  logic       wrap_p;
  logic [7:0] wrap_cnt;
  logic       evt_valid;
  logic       evt_ready;
  logic [4:0] evt_data;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  logic saw_low;

  ripple_count_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .thresh    (thresh),
    .clr       (clr),
    .cnt_sync  (cnt_sync),
    .stable    (stable),
    .match_p   (match_p),
    .wrap_p    (wrap_p),
    .wrap_cnt  (wrap_cnt),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cnt_sync"},  32'(cnt_sync),  32'h0);
    chk({tag, ".stable"},    32'(stable),    32'h0);
    chk({tag, ".match_p"},   32'(match_p),   32'h0);
    chk({tag, ".wrap_p"},    32'(wrap_p),    32'h0);
    chk({tag, ".wrap_cnt"},  32'(wrap_cnt),  32'h0);
    chk({tag, ".evt_valid"}, 32'(evt_valid), 32'h0);
    chk({tag, ".evt_data"},  32'(evt_data),  32'h0);
    chk({tag, ".ovf"},       32'(ovf),       32'h0);
  endtask

  initial begin
    rst = 1'b0; cnt_in = 4'h0; thresh = 4'hA; clr = 1'b0; evt_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    step(4);

    // Clean change 0 -> 3 commits on the 6th rising edge
    cnt_in = 4'h3;
    step(5);
    chk("settle.before6", 32'(cnt_sync), 32'h0);
    step(1);
    chk("settle.cnt_sync", 32'(cnt_sync),  32'h3);
    chk("settle.valid",    32'(evt_valid), 32'h1);
    chk("settle.data",     32'(evt_data),  32'h03);
    chk("settle.match",    32'(match_p),   32'h0);
    step(1);
    chk("settle.valid_drop", 32'(evt_valid), 32'h0);

    // One-cycle glitch to 2 must never commit
    step(2);
    cnt_in = 4'h2;
    step(1);
    cnt_in = 4'h3;
    saw_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!stable) saw_low = 1'b1;
      chk("glitch.cnt_sync", 32'(cnt_sync),  32'h3);
      chk("glitch.no_evt",   32'(evt_valid), 32'h0);
    end
    chk("glitch.stable_dropped", 32'(saw_low), 32'h1);
    chk("glitch.stable_back",    32'(stable),  32'h1);

    // Wrap from F to 0
    cnt_in = 4'hF;
    step(6);
    chk("upF.cnt_sync", 32'(cnt_sync), 32'hF);
    chk("upF.wrap_p",   32'(wrap_p),   32'h0);
    chk("upF.data",     32'(evt_data), 32'h0F);
    step(1);
    cnt_in = 4'h0;
    step(6);
    chk("wrap.cnt_sync", 32'(cnt_sync),  32'h0);
    chk("wrap.wrap_p",   32'(wrap_p),    32'h1);
    chk("wrap.wrap_cnt", 32'(wrap_cnt),  32'h1);
    chk("wrap.data",     32'(evt_data),  32'h10);
    chk("wrap.valid",    32'(evt_valid), 32'h1);
    step(1);
    chk("wrap.pulse_end", 32'(wrap_p), 32'h0);

    // Back-pressure: the second event is dropped and sets ovf
    evt_ready = 1'b0;
    cnt_in = 4'h1;
    step(6);
    chk("bp.first_valid", 32'(evt_valid), 32'h1);
    chk("bp.first_data",  32'(evt_data),  32'h01);
    cnt_in = 4'h2;
    step(6);
    chk("bp.cnt_sync",  32'(cnt_sync),  32'h2);
    chk("bp.data_held", 32'(evt_data),  32'h01);
    chk("bp.ovf",       32'(ovf),       32'h1);
    step(3);
    chk("bp.ovf_sticky", 32'(ovf), 32'h1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr.ovf",      32'(ovf),       32'h0);
    chk("clr.valid",    32'(evt_valid), 32'h0);
    chk("clr.wrap_cnt", 32'(wrap_cnt),  32'h0);
    evt_ready = 1'b1;

    // Threshold match
    thresh = 4'h5;
    cnt_in = 4'h5;
    step(6);
    chk("match.pulse",    32'(match_p),  32'h1);
    chk("match.no_wrap",  32'(wrap_p),   32'h0);
    chk("match.data",     32'(evt_data), 32'h05);
    step(1);
    chk("match.pulse_end", 32'(match_p), 32'h0);

    // 255 wraps fill the counter, and one more must saturate
    for (int i = 0; i < 255; i++) begin
      cnt_in = 4'h0;
      step(7);
      cnt_in = 4'h5;
      step(7);
    end
    chk("sat.wrap_cnt_255", 32'(wrap_cnt), 32'hFF);
    cnt_in = 4'h0;
    step(6);
    chk("sat.wrap_p",     32'(wrap_p),   32'h1);
    chk("sat.wrap_cnt",   32'(wrap_cnt), 32'hFF);
    step(2);

    // Reset mid-settling discards the pending value
    cnt_in = 4'h9;
    step(3);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    step(5);
    chk("midrst.not_yet", 32'(cnt_sync), 32'h0);
    step(1);
    chk("midrst.commit",  32'(cnt_sync), 32'h9);
    chk("midrst.no_wrap", 32'(wrap_p),   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
